// File: rtl/mem_io_control_if.sv
// rtl/mem_io_control_if.sv - pipeline, memory and UART signal bundle for mem_io_control
interface mem_io_control_if;
  logic        stall;
  logic [31:0] PC;
  logic [31:0] addr;
  logic        mem_we;
  logic        mem_re;
  logic [1:0]  size;
  logic [31:0] store_data;
  logic [31:0] wdata;
  logic [3:0]  dmem_we;
  logic [3:0]  imem_we;
  logic        mmio_sel;
  logic [31:0] mmio_rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic        instr_retired;

  modport master (
    output stall, PC, addr, mem_we, mem_re, size, store_data,
           uart_tx_ready, uart_rx_data, uart_rx_valid, instr_retired,
    input  wdata, dmem_we, imem_we, mmio_sel, mmio_rdata,
           uart_tx_data, uart_tx_valid, uart_rx_ready
  );

  modport slave (
    input  stall, PC, addr, mem_we, mem_re, size, store_data,
           uart_tx_ready, uart_rx_data, uart_rx_valid, instr_retired,
    output wdata, dmem_we, imem_we, mmio_sel, mmio_rdata,
           uart_tx_data, uart_tx_valid, uart_rx_ready
  );
endinterface

// File: rtl/mem_io_control.sv
// rtl/mem_io_control.sv - data-side address decode, store alignment and MMIO registers
module mem_io_control #(
  parameter int CNT_W = 32
) (
  input logic            clk,
  input logic            reset,
  mem_io_control_if.slave io
);
  localparam logic [3:0] RGN_DMEM = 4'h1;
  localparam logic [3:0] RGN_IMEM = 4'h2;
  localparam logic [3:0] RGN_BOTH = 4'h3;
  localparam logic [3:0] RGN_BIOS = 4'h4;
  localparam logic [3:0] RGN_MMIO = 4'h8;

  localparam logic [4:0] OFF_TX_RDY  = 5'h00;
  localparam logic [4:0] OFF_RX_VLD  = 5'h04;
  localparam logic [4:0] OFF_RX_DATA = 5'h08;
  localparam logic [4:0] OFF_TX_DATA = 5'h0C;
  localparam logic [4:0] OFF_CYC     = 5'h10;
  localparam logic [4:0] OFF_INS     = 5'h14;
  localparam logic [4:0] OFF_CLR     = 5'h18;

  typedef enum logic {TX_IDLE, TX_PEND} tx_state_e;

  tx_state_e        tx_state_q, tx_state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, ins_q, ins_d;
  logic             sel_q, sel_d;
  logic [31:0]      rdata_q, rdata_d;

  logic        go, is_mmio, mmio_wr, mmio_rd, tx_busy;
  logic [3:0]  region;
  logic [4:0]  offset;
  logic [3:0]  mask;
  logic [31:0] wdata_c, rd_val;
  logic        unused_bits;

  assign go       = !reset && !io.stall;
  assign region   = io.addr[31:28];
  assign offset   = io.addr[4:0];
  assign is_mmio  = (region == RGN_MMIO);
  assign mmio_wr  = go && io.mem_we && is_mmio;
  assign mmio_rd  = go && io.mem_re && is_mmio;
  assign tx_busy  = (tx_state_q == TX_PEND);
  assign unused_bits = &{1'b0, io.PC[27:0], io.addr[27:5]};

  // Misaligned halves/words and the reserved size produce no lanes at all.
  always_comb begin
    mask = 4'b0000;
    case (io.size)
      2'b00:   mask[io.addr[1:0]] = 1'b1;
      2'b01:   if (!io.addr[0]) mask = io.addr[1] ? 4'b1100 : 4'b0011;
      2'b10:   if (io.addr[1:0] == 2'b00) mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
  end

  always_comb begin
    wdata_c = io.store_data;
    case (io.size)
      2'b00:   wdata_c = {4{io.store_data[7:0]}};
      2'b01:   wdata_c = {2{io.store_data[15:0]}};
      default: wdata_c = io.store_data;
    endcase
  end

  assign io.wdata   = wdata_c;
  assign io.dmem_we = (go && io.mem_we && (region == RGN_DMEM || region == RGN_BOTH)) ? mask : 4'b0000;
  assign io.imem_we = (go && io.mem_we && (region == RGN_IMEM || region == RGN_BOTH) &&
                       io.PC[31:28] == RGN_BIOS) ? mask : 4'b0000;
  assign io.uart_rx_ready = mmio_rd && (offset == OFF_RX_DATA) && io.uart_rx_valid;

  always_comb begin
    rd_val = 32'h0;
    case (offset)
      OFF_TX_RDY:  rd_val = {31'b0, !tx_busy};
      OFF_RX_VLD:  rd_val = {31'b0, io.uart_rx_valid};
      OFF_RX_DATA: rd_val = {24'b0, io.uart_rx_data};
      OFF_CYC:     rd_val = 32'(cyc_q);
      OFF_INS:     rd_val = 32'(ins_q);
      default:     rd_val = 32'h0;
    endcase
  end

  always_comb begin
    sel_d      = sel_q;
    rdata_d    = rdata_q;
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    cyc_d      = cyc_q + CNT_W'(1);
    ins_d      = ins_q + CNT_W'(io.instr_retired);
    if (go) begin
      sel_d = mmio_rd;
      if (mmio_rd) rdata_d = rd_val;
    end
    case (tx_state_q)
      TX_IDLE: if (mmio_wr && offset == OFF_TX_DATA) begin
        tx_state_d = TX_PEND;
        tx_data_d  = io.store_data[7:0];
      end
      TX_PEND: if (io.uart_tx_ready) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
    // Clear wins over the same-cycle increment.
    if (mmio_wr && offset == OFF_CLR) begin
      cyc_d = '0;
      ins_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_data_q  <= 8'h00;
      cyc_q      <= '0;
      ins_q      <= '0;
      sel_q      <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_data_q  <= tx_data_d;
      cyc_q      <= cyc_d;
      ins_q      <= ins_d;
      sel_q      <= sel_d;
      rdata_q    <= rdata_d;
    end
  end

  assign io.uart_tx_valid = tx_busy;
  assign io.uart_tx_data  = tx_data_q;
  assign io.mmio_sel      = sel_q;
  assign io.mmio_rdata    = rdata_q;
endmodule

// File: doc/mem_io_control.md
Name: mem_io_control

Overview:
- Data-side address decoder and memory-mapped I/O block for the MIPS150 pipeline.
- Complements the fetch-side instruction-source decode. Turns a load/store address, size and the issuing PC into per-byte write enables for DMEM and IMEM, and aligns store data.
- Owns the MMIO register file: UART TX/RX handshake registers, cycle counter and instruction counter.
- MMIO load data is registered, giving the same one-cycle latency as the block RAMs so the writeback mux is uniform.

Parameters:
- CNT_W, 32, width of the cycle and instruction counters (zero-extended to 32 on read).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  pipeline stall; blocks all side effects this cycle
- PC  input  32  PC of the memory instruction
- addr  input  32  effective byte address
- mem_we  input  1  store issued
- mem_re  input  1  load issued
- size  input  2  00 byte, 01 half, 10 word, 11 reserved
- store_data  input  32  unaligned store data from register file
- wdata  output  32  store data replicated into byte lanes
- dmem_we  output  4  DMEM byte write enables
- imem_we  output  4  IMEM byte write enables
- mmio_sel  output  1  registered; writeback takes mmio_rdata this cycle
- mmio_rdata  output  32  registered MMIO load data
- uart_tx_data  output  8  byte to transmitter
- uart_tx_valid  output  1  transmit request
- uart_tx_ready  input  1  transmitter can accept
- uart_rx_data  input  8  received byte
- uart_rx_valid  input  1  receiver holds a byte
- uart_rx_ready  output  1  one-cycle pop of receiver byte
- instr_retired  input  1  one instruction retired this cycle

Behaviour:
- Commit condition: `go = !reset && !stall`. No write enable, pop, TX launch or counter clear occurs without `go`. Free-running counting is the only exception and pauses only on reset.
- Byte mask:
  - byte: lane addr[1:0].
  - half: lanes {addr[1],x}. addr[0]=1 gives mask 0000 (misaligned, dropped).
  - word: 1111 only if addr[1:0]=00, else 0000.
  - size 11 gives 0000.
- wdata lane replication: byte replicated ×4; half replicated ×2; word passed through.
- dmem_we = mask when mem_we, go and addr[31:28] ∈ {0001, 0011}.
- imem_we = mask when mem_we, go, addr[31:28] ∈ {0010, 0011} and PC[31:28]=0100. Only code running from BIOS may write IMEM; otherwise 0000.
- Address 0011 writes both DMEM and IMEM in the same cycle.
- MMIO region addr[31:28]=1000, decoded on addr[4:0]:
  - 0x00 R: {31'b0, tx_ready_eff}, where tx_ready_eff = !uart_tx_valid.
  - 0x04 R: {31'b0, uart_rx_valid}.
  - 0x08 R: {24'b0, uart_rx_data}. On a load, uart_rx_ready pulses high for the same (load) cycle, gated by go and uart_rx_valid.
  - 0x0C W: if !uart_tx_valid, latch store_data[7:0] into uart_tx_data and set uart_tx_valid next cycle. A write while uart_tx_valid=1 is dropped; data is not overwritten.
  - 0x10 R: cycle counter.
  - 0x14 R: instruction counter.
  - 0x18 W: both counters become 0 next cycle.
  - Unmapped offsets: reads return 0, writes are ignored.
- TX handshake: uart_tx_valid stays high until a cycle with uart_tx_ready=1, then clears on the next edge. A new 0x0C store in that same clearing cycle is dropped (valid was still 1).
- Counters:
  - Cycle counter increments every non-reset cycle, including stalls.
  - Instruction counter increments when instr_retired=1.
  - Both wrap modulo 2^CNT_W.
  - A clear store takes priority over a same-cycle increment: the result is 0.
  - A counter read returns the pre-edge value.
- Read path: on a go cycle with mem_re and an MMIO address, mmio_sel=1 and mmio_rdata=value on the next cycle. Otherwise mmio_sel=0 next cycle. While stall=1, mmio_sel and mmio_rdata hold their values.
- Reset values: mmio_sel=0, mmio_rdata=0, uart_tx_valid=0, uart_tx_data=0, both counters 0. Combinational enables are 0 while reset=1.
- Reset mid-TX: a pending TX request is abandoned and valid drops on the reset edge.

Test Plan:
- Store word 0xDEADBEEF to 0x10000008, PC=0x00400000 → dmem_we=1111, imem_we=0000, wdata=0xDEADBEEF.
- Store byte 0xA5 to 0x30000003, PC=0x40000010 → dmem_we=imem_we=1000, wdata=0xA5A5A5A5. Same store with PC=0x10000010 → imem_we=0000. Store half to 0x10000001 → dmem_we=0000.
- Store 0x41 to 0x8000000C with tx_ready=0 for 3 cycles, then 1 → tx_valid high for 4 cycles, tx_data=0x41. A second store during that window is dropped. A load of 0x80000000 returns 0 while pending and 1 after.
- rx_valid=1, rx_data=0x7E; load 0x80000008 → rx_ready pulses 1 cycle; next cycle mmio_sel=1, mmio_rdata=0x0000007E. Same load with stall=1 → no pulse, outputs hold.
- Run 10 cycles with instr_retired on 6 of them; load 0x80000010 and 0x80000014 → 10 and 6. Store to 0x80000018 on a retire cycle → both counters read 0 one cycle later.
- Preload cycle counter 0xFFFFFFFF → wraps to 0. Assert reset with tx_valid=1 → all outputs at reset values on the next edge.
